// File: rtl/alu_mem_stage.sv
// Execute/memory stage of the 24-bit single-cycle CPU.
// ALU control decode, 24-bit ALU with flags and 48-bit signed product,
// and a byte-addressed big-endian data memory with wrap-around addressing.
module alu_mem_stage #(
   parameter int DEPTH = 256,  // data memory size in bytes (power of two)
   parameter int AW    = 8     // byte address bits, log2(DEPTH)
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [1:0]  ALUOp,
   input  logic [3:0]  Funct,
   input  logic [3:0]  Shamt,
   input  logic [23:0] A,
   input  logic [23:0] B,
   input  logic [23:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [3:0]  ALUCtrl,
   output logic [23:0] Result,
   output logic        Zero,
   output logic        Overflow,
   output logic        CarryOut,
   output logic [47:0] Product,
   output logic [23:0] MemData
);

   // ALU operation field encodings (ALUCtrl[2:0]); ALUCtrl[3] inverts B.
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_SLL = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic [3:0]  alu_ctrl;
   logic        b_inv;
   logic [2:0]  alu_op;
   logic [23:0] b_op;
   logic [24:0] sum;
   logic        add_ovf;
   logic [47:0] a_ext;
   logic [47:0] b_ext;
   logic [47:0] product;
   logic [23:0] result;
   logic        overflow;
   logic        carry_out;

   // ------------------------------------------------------------------
   // ALU control decode
   // ------------------------------------------------------------------

   // Map the main-decoder class and Funct field onto a 4-bit ALU control word.
   always_comb begin
      alu_ctrl = 4'b0010;
      case (ALUOp)
         2'b00: alu_ctrl = 4'b0010;
         2'b01: alu_ctrl = 4'b1010;
         2'b11: alu_ctrl = 4'b1111;
         default: begin
            case (Funct)
               4'b0000: alu_ctrl = 4'b0010;
               4'b0001: alu_ctrl = 4'b1010;
               4'b0010: alu_ctrl = 4'b0000;
               4'b0011: alu_ctrl = 4'b0001;
               4'b0100: alu_ctrl = 4'b0011;
               4'b0101: alu_ctrl = 4'b1111;
               4'b0110: alu_ctrl = 4'b0100;
               4'b0111: alu_ctrl = 4'b0101;
               4'b1000: alu_ctrl = 4'b0110;
               default: alu_ctrl = 4'b0010;
            endcase
         end
      endcase
   end

   assign ALUCtrl = alu_ctrl;
   assign b_inv   = alu_ctrl[3];
   assign alu_op  = alu_ctrl[2:0];

   // ------------------------------------------------------------------
   // ALU datapath
   // ------------------------------------------------------------------

   // Shared adder: A + B, or A + ~B + 1 when B-invert is set (SUB and SLT).
   always_comb begin
      b_op    = b_inv ? ~B : B;
      sum     = {1'b0, A} + {1'b0, b_op} + {24'd0, b_inv};
      // Signed overflow: both adder inputs share a sign that the sum lacks.
      add_ovf = (A[23] == b_op[23]) && (sum[23] != A[23]);
   end

   // Full-width signed multiply; sign-extending both operands to 48 bits
   // makes the low 48 bits of the unsigned product equal the signed product.
   always_comb begin
      a_ext   = {{24{A[23]}}, A};
      b_ext   = {{24{B[23]}}, B};
      product = a_ext * b_ext;
   end

   assign Product = product;

   // Select the result for the decoded operation; flags only on ADD/SUB.
   always_comb begin
      result    = 24'd0;
      overflow  = 1'b0;
      carry_out = 1'b0;
      case (alu_op)
         OP_AND: result = A & B;
         OP_OR:  result = A | B;
         OP_XOR: result = A ^ B;
         OP_ADD: begin
            result    = sum[23:0];
            overflow  = add_ovf;
            carry_out = sum[24];
         end
         OP_SLL: result = A << Shamt;
         OP_SRL: result = A >> Shamt;
         OP_MUL: result = product[23:0];
         OP_SLT: begin
            // Only the inverted form is a real SLT; code 0111 yields zero.
            if (b_inv) begin
               result = {23'd0, sum[23] ^ add_ovf};
            end
         end
         default: result = 24'd0;
      endcase
   end

   assign Result   = result;
   assign Overflow = overflow;
   assign CarryOut = carry_out;
   assign Zero     = (result == 24'd0);

   // ------------------------------------------------------------------
   // Data memory
   // ------------------------------------------------------------------

   logic [AW-1:0]      addr0;
   logic [AW-1:0]      addr1;
   logic [AW-1:0]      addr2;
   logic [DEPTH*8-1:0] mem_flat;
   logic [7:0]         rd_byte0;
   logic [7:0]         rd_byte1;
   logic [7:0]         rd_byte2;

   // Three consecutive byte addresses; AW-bit arithmetic gives the wrap.
   always_comb begin
      addr0 = result[AW-1:0];
      addr1 = addr0 + AW'(1);
      addr2 = addr0 + AW'(2);
   end

   // Each byte is its own register so the whole array clears on Reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_byte
         localparam logic [AW-1:0] IDX = AW'(gi);
         logic [7:0] byte_q;
         logic [7:0] byte_d;

         // Pick the store byte that lands here, big-endian within the word.
         always_comb begin
            byte_d = byte_q;
            if (MemWrite) begin
               if (addr0 == IDX) begin
                  byte_d = WriteData[23:16];
               end else if (addr1 == IDX) begin
                  byte_d = WriteData[15:8];
               end else if (addr2 == IDX) begin
                  byte_d = WriteData[7:0];
               end
            end
         end

         // Byte storage; Reset clears it immediately and blocks writes.
         always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
               byte_q <= 8'd0;
            end else begin
               byte_q <= byte_d;
            end
         end

         assign mem_flat[gi*8 +: 8] = byte_q;
      end
   endgenerate

   // Combinational big-endian word read, gated by MemRead.
   always_comb begin
      rd_byte0 = mem_flat[{addr0, 3'b000} +: 8];
      rd_byte1 = mem_flat[{addr1, 3'b000} +: 8];
      rd_byte2 = mem_flat[{addr2, 3'b000} +: 8];
      MemData  = MemRead ? {rd_byte0, rd_byte1, rd_byte2} : 24'd0;
   end

endmodule

// File: tb/tb_alu_mem_stage.sv
// Directed testbench for alu_mem_stage: decode, ALU ops/flags, product,
// data memory write/read, address wrap and asynchronous reset.
module tb_alu_mem_stage;

   logic        Clock;
   logic        Reset;
   logic [1:0]  ALUOp;
   logic [3:0]  Funct;
   logic [3:0]  Shamt;
   logic [23:0] A;
   logic [23:0] B;
   logic [23:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [3:0]  ALUCtrl;
   logic [23:0] Result;
   logic        Zero;
   logic        Overflow;
   logic        CarryOut;
   logic [47:0] Product;
   logic [23:0] MemData;

   int checks = 0;
   int errors = 0;

   alu_mem_stage #(.DEPTH(256), .AW(8)) dut (
      .Clock(Clock), .Reset(Reset), .ALUOp(ALUOp), .Funct(Funct),
      .Shamt(Shamt), .A(A), .B(B), .WriteData(WriteData),
      .MemWrite(MemWrite), .MemRead(MemRead), .ALUCtrl(ALUCtrl),
      .Result(Result), .Zero(Zero), .Overflow(Overflow),
      .CarryOut(CarryOut), .Product(Product), .MemData(MemData)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply an ALU vector just after a falling edge and let it settle.
   task automatic drive(input logic [1:0] op, input logic [3:0] fn, input logic [3:0] sh,
                        input logic [23:0] a, input logic [23:0] b);
      @(negedge Clock);
      ALUOp = op; Funct = fn; Shamt = sh; A = a; B = b;
      #1;
      $display("vec op=%b funct=%b shamt=%0d A=%h B=%h -> ctrl=%b res=%h z=%b v=%b c=%b prod=%h",
               op, fn, sh, a, b, ALUCtrl, Result, Zero, Overflow, CarryOut, Product);
   endtask

   // Memory access through ALUOp=00 (address = 0 + b).
   task automatic read_at(input logic [23:0] addr);
      drive(2'b00, 4'b0000, 4'd0, 24'd0, addr);
      $display("rd addr=%0d data=%h", addr, MemData);
   endtask

   task automatic write_at(input logic [23:0] addr, input logic [23:0] data, input string tag);
      drive(2'b00, 4'b0000, 4'd0, 24'd0, addr);
      WriteData = data; MemWrite = 1'b1; MemRead = 1'b1;
      #1;
      check({tag, "_old"}, {24'd0, MemData}, 48'd0);
      @(posedge Clock);
      #1;
      MemWrite = 1'b0;
      $display("wr addr=%0d data=%h readback=%h", addr, data, MemData);
      check({tag, "_new"}, {24'd0, MemData}, {24'd0, data});
   endtask

   initial begin
      Reset = 1'b0; ALUOp = 2'b00; Funct = 4'd0; Shamt = 4'd0;
      A = 24'd0; B = 24'd9; WriteData = 24'd0; MemWrite = 1'b0; MemRead = 1'b1;

      // Reset asserted mid-cycle; a write attempted during reset is dropped.
      #3 Reset = 1'b1;
      #1;
      check("rst_memdata", {24'd0, MemData}, 48'd0);
      WriteData = 24'h111111; MemWrite = 1'b1;
      @(posedge Clock); #1;
      check("rst_write_dropped", {24'd0, MemData}, 48'd0);
      MemWrite = 1'b0;
      @(negedge Clock);
      Reset = 1'b0;

      read_at(24'd9);
      check("post_rst_read9", {24'd0, MemData}, 48'd0);

      // Store then load, including same-cycle read/write at address 9.
      write_at(24'd9, 24'hABCDEF, "wr9");
      read_at(24'd8);
      check("byte9_is_AB", {24'd0, MemData}, {24'd0, 24'h00ABCD});
      read_at(24'd11);
      check("byte11_is_EF", {24'd0, MemData}, {24'd0, 24'hEF0000});

      // ADD with signed overflow.
      drive(2'b10, 4'b0000, 4'd0, 24'h7FFFFF, 24'h000001);
      check("add_res", {24'd0, Result}, {24'd0, 24'h800000});
      check("add_ovf", {47'd0, Overflow}, 48'd1);
      check("add_carry", {47'd0, CarryOut}, 48'd0);
      check("add_ctrl", {44'd0, ALUCtrl}, {44'd0, 4'b0010});
      check("add_prod", Product, 48'h0000007FFFFF);

      // ADD with carry out and zero result.
      drive(2'b10, 4'b0000, 4'd0, 24'hFFFFFF, 24'h000001);
      check("addc_res", {24'd0, Result}, 48'd0);
      check("addc_carry", {47'd0, CarryOut}, 48'd1);
      check("addc_ovf", {47'd0, Overflow}, 48'd0);
      check("addc_zero", {47'd0, Zero}, 48'd1);

      // SUB equal operands.
      drive(2'b10, 4'b0001, 4'd0, 24'd5, 24'd5);
      check("sub_res", {24'd0, Result}, 48'd0);
      check("sub_zero", {47'd0, Zero}, 48'd1);
      check("sub_carry", {47'd0, CarryOut}, 48'd1);
      check("sub_ctrl", {44'd0, ALUCtrl}, {44'd0, 4'b1010});

      // Bitwise ops.
      drive(2'b10, 4'b0010, 4'd0, 24'hF0F0F0, 24'hFF00FF);
      check("and_res", {24'd0, Result}, {24'd0, 24'hF000F0});
      check("and_ctrl", {44'd0, ALUCtrl}, {44'd0, 4'b0000});
      drive(2'b10, 4'b0011, 4'd0, 24'hF0F0F0, 24'hFF00FF);
      check("or_res", {24'd0, Result}, {24'd0, 24'hFFF0FF});
      drive(2'b10, 4'b0100, 4'd0, 24'hF0F0F0, 24'hFF00FF);
      check("xor_res", {24'd0, Result}, {24'd0, 24'h0FF00F});

      // Signed multiply; flags stay clear for non-add operations.
      drive(2'b10, 4'b1000, 4'd0, 24'hFFFFFE, 24'd3);
      check("mul_prod", Product, 48'hFFFFFFFFFFFA);
      check("mul_res", {24'd0, Result}, {24'd0, 24'hFFFFFA});
      check("mul_ctrl", {44'd0, ALUCtrl}, {44'd0, 4'b0110});
      check("mul_carry", {47'd0, CarryOut}, 48'd0);
      check("mul_ovf", {47'd0, Overflow}, 48'd0);

      // Set-less-than, R-type and immediate class.
      drive(2'b10, 4'b0101, 4'd0, 24'hFFFFFE, 24'd3);
      check("slt_res", {24'd0, Result}, 48'd1);
      check("slt_ctrl", {44'd0, ALUCtrl}, {44'd0, 4'b1111});
      drive(2'b11, 4'b0000, 4'd0, 24'd3, 24'hFFFFFE);
      check("slti_res", {24'd0, Result}, 48'd0);
      check("slti_zero", {47'd0, Zero}, 48'd1);

      // Shifts, including maximum and zero shift amounts.
      drive(2'b10, 4'b0110, 4'd15, 24'h000001, 24'd0);
      check("sll15", {24'd0, Result}, {24'd0, 24'h008000});
      drive(2'b10, 4'b0111, 4'd4, 24'h800000, 24'd0);
      check("srl4", {24'd0, Result}, {24'd0, 24'h080000});
      drive(2'b10, 4'b0111, 4'd0, 24'h800000, 24'd0);
      check("srl0", {24'd0, Result}, {24'd0, 24'h800000});
      drive(2'b10, 4'b0110, 4'd0, 24'h123456, 24'd0);
      check("sll0", {24'd0, Result}, {24'd0, 24'h123456});

      // Decode default and beq class.
      drive(2'b10, 4'b1111, 4'd0, 24'd1, 24'd2);
      check("dflt_ctrl", {44'd0, ALUCtrl}, {44'd0, 4'b0010});
      check("dflt_res", {24'd0, Result}, 48'd3);
      drive(2'b01, 4'b0000, 4'd0, 24'd7, 24'd7);
      check("beq_zero", {47'd0, Zero}, 48'd1);
      check("beq_ctrl", {44'd0, ALUCtrl}, {44'd0, 4'b1010});

      // Address wrap-around at the top of memory.
      write_at(24'd255, 24'h123456, "wr255");
      read_at(24'd0);
      check("wrap_read0", {24'd0, MemData}, {24'd0, 24'h345600});
      read_at(24'd1);
      check("wrap_read1", {24'd0, MemData}, {24'd0, 24'h560000});
      MemRead = 1'b0;
      #1;
      check("memread_off", {24'd0, MemData}, 48'd0);
      MemRead = 1'b1;

      // Asynchronous reset mid-cycle clears memory at once.
      read_at(24'd255);
      check("pre_rst255", {24'd0, MemData}, {24'd0, 24'h123456});
      Reset = 1'b1;
      #1;
      check("async_rst255", {24'd0, MemData}, 48'd0);
      @(negedge Clock);
      Reset = 1'b0;
      read_at(24'd9);
      check("after_rst9", {24'd0, MemData}, 48'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
